// File: rtl/shift_wb_commit_if.sv
// EX-to-writeback handshake bundle: EX pushes completed shift ops (ex_*),
// writeback drains the head entry (wb_*).
interface shift_wb_commit_if;
  logic        ex_v;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_flags;
  logic [31:0] ex_flag_mask;
  logic [4:0]  ex_count;
  logic [1:0]  ex_datasize;
  logic [2:0]  ex_dest;
  logic        ex_wr_en;
  logic        wb_v;
  logic        wb_ready;
  logic [31:0] wb_result;
  logic [3:0]  wb_byte_en;
  logic [2:0]  wb_dest;
  logic        wb_wr_en;

  // The commit stage is the slave: it consumes ex_* and produces wb_*.
  modport slave (
    input  ex_v, ex_result, ex_flags, ex_flag_mask, ex_count, ex_datasize,
           ex_dest, ex_wr_en, wb_ready,
    output ex_ready, wb_v, wb_result, wb_byte_en, wb_dest, wb_wr_en
  );

  modport master (
    output ex_v, ex_result, ex_flags, ex_flag_mask, ex_count, ex_datasize,
           ex_dest, ex_wr_en, wb_ready,
    input  ex_ready, wb_v, wb_result, wb_byte_en, wb_dest, wb_wr_en
  );
endinterface

// File: rtl/shift_wb_commit.sv
// Two-entry skid buffer between the shifter and the register-file write port;
// merges shifter flags into EFLAGS as each op retires, following x86 shift rules.
module shift_wb_commit #(
  parameter int unsigned DEPTH        = 2,
  parameter logic [31:0] EFLAGS_RESET = 32'h0000_0002
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  shift_wb_commit_if.slave   bus,
  output logic [31:0]        eflags,
  output logic [1:0]         state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds valid and payload stable until it does.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        head, tail;
  logic        push, pop;
  logic [31:0] res_q [2];
  logic [31:0] flg_q [2];
  logic [31:0] msk_q [2];
  logic [4:0]  cnt_q [2];
  logic [1:0]  ds_q  [2];
  logic [2:0]  dst_q [2];
  logic        wr_q  [2];
  logic [31:0] eff_mask;
  logic [31:0] res_h;

  assign bus.ex_ready = (state != FULL);
  assign bus.wb_v     = (state != EMPTY);
  assign push         = bus.ex_v & bus.ex_ready;
  assign pop          = bus.wb_v & bus.wb_ready;
  assign state_dbg    = state;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE:     if (push && !pop) state_nxt = FULL;
                 else if (pop && !push) state_nxt = EMPTY;
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Count 0 writes nothing; OF (bit 11) is only written by a 1-bit shift.
  always_comb begin
    eff_mask = 32'h0;
    if (cnt_q[head] != 5'd0) begin
      eff_mask = msk_q[head];
      if (cnt_q[head] != 5'd1) eff_mask[11] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= EMPTY;
      head   <= 1'b0;
      tail   <= 1'b0;
      eflags <= EFLAGS_RESET;
    end else begin
      state <= state_nxt;
      if (flush) begin
        head <= 1'b0;
        tail <= 1'b0;
      end else begin
        if (push) tail <= ~tail;
        if (pop) begin
          head   <= ~head;
          eflags <= (eflags & ~eff_mask) | (flg_q[head] & eff_mask) | 32'h2;
        end
      end
    end
  end

  // Payload storage carries no reset; outputs are gated by wb_v instead.
  always_ff @(posedge clk) begin
    if (push) begin
      res_q[tail] <= bus.ex_result;
      flg_q[tail] <= bus.ex_flags;
      msk_q[tail] <= bus.ex_flag_mask;
      cnt_q[tail] <= bus.ex_count;
      ds_q[tail]  <= bus.ex_datasize;
      dst_q[tail] <= bus.ex_dest;
      wr_q[tail]  <= bus.ex_wr_en;
    end
  end

  always_comb begin
    res_h          = res_q[head];
    bus.wb_result  = 32'h0;
    bus.wb_byte_en = 4'b0000;
    bus.wb_dest    = 3'd0;
    bus.wb_wr_en   = 1'b0;
    if (bus.wb_v) begin
      bus.wb_dest  = dst_q[head];
      bus.wb_wr_en = wr_q[head];
      case (ds_q[head])
        2'd0: begin
          bus.wb_result  = {24'h0, res_h[7:0]};
          bus.wb_byte_en = 4'b0001;
        end
        2'd1: begin
          bus.wb_result  = {16'h0, res_h[15:0]};
          bus.wb_byte_en = 4'b0011;
        end
        default: begin
          bus.wb_result  = res_h;
          bus.wb_byte_en = 4'b1111;
        end
      endcase
    end
  end

  a_occupancy: assert property (@(posedge clk) disable iff (!reset)
    int'(state) <= int'(DEPTH));

endmodule

// File: doc/shift_wb_commit.md
Name: shift_wb_commit

Overview:
- Execute-to-writeback stage that consumes the shifter's result and flag outputs.
- Buffers up to two completed shift ops in a skid buffer, then presents them to the register-file write port.
- Merges the shifter flags into the architectural EFLAGS register when an op retires.
- Applies the x86 shift flag rules: count 0 leaves flags unchanged; OF is written only for a 1-bit shift.

Parameters:
DEPTH, 2, skid-buffer entries; the design is fixed at 2, and the parameter exists for documentation and assertions only.
EFLAGS_RESET, 32'h0000_0002, EFLAGS value after reset (bit 1 reserved-one).

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-low
flush  in  1  discard all buffered ops; EFLAGS untouched
ex_v  in  1  EX holds a valid shift op
ex_ready  out  1  stage can accept an op this cycle
ex_result  in  32  shift result
ex_flags  in  32  shift flags in EFLAGS positions: CF0, PF2, AF4, ZF6, SF7, DF10, OF11
ex_flag_mask  in  32  decode flag-overwrite mask (1 = flag is written)
ex_count  in  5  masked shift count
ex_datasize  in  2  0 = byte, 1 = word, 2 = dword, 3 = reserved (treated as dword)
ex_dest  in  3  destination register number
ex_wr_en  in  1  op writes a register
wb_v  out  1  head entry valid
wb_ready  in  1  writeback accepts the head entry
wb_result  out  32  head result, masked to datasize
wb_byte_en  out  4  byte enables: byte 4'b0001, word 4'b0011, dword 4'b1111
wb_dest  out  3  head destination
wb_wr_en  out  1  head ex_wr_en AND wb_v
eflags  out  32  architectural EFLAGS, registered

Behaviour:
- All state updates on rising clk. When reset is low at an edge:
  - count = 0, so wb_v = 0 and ex_ready = 1.
  - eflags = EFLAGS_RESET.
  - Entry payloads are don't-care; wb_result, wb_byte_en, wb_dest and wb_wr_en read 0 whenever wb_v = 0.
- push = ex_v & ex_ready; pop = wb_v & wb_ready.
- Occupancy states: EMPTY (0), ONE (1), FULL (2).
  - EMPTY: push -> ONE.
  - ONE: push & ~pop -> FULL; pop & ~push -> EMPTY; push & pop -> ONE, with the new entry becoming head next cycle.
  - FULL: pop -> ONE; push cannot occur.
- ex_ready = (state != FULL). It is registered-state-derived only; no combinational path from wb_ready.
- Latency: an op pushed in cycle N appears on wb_v in cycle N+1 when the buffer was EMPTY, or when ONE with a simultaneous pop.
- Ordering is strict FIFO. Head pointer toggles on pop; tail pointer toggles on push.
- On pop, EFLAGS is committed as follows:
  - eff_mask = (count_h == 0) ? 0 : (mask_h & ~((count_h != 1) << 11)).
  - eflags <= (eflags & ~eff_mask) | (flags_h & eff_mask) | 32'h2.
  - Bit 1 is always 1.
- Result masking: byte zero-extends bits [7:0]; word zero-extends bits [15:0]; dword passes all bits.
- Flush has priority over push and pop in the same cycle: state -> EMPTY, pointers reset, no EFLAGS commit for the head. It takes effect at the next edge.
- Reset low has priority over flush. Reset in mid-operation drops all entries; no partial commit.
- Push when ex_ready = 0 is ignored and the payload is not captured. The bench asserts that EX holds ex_v and payload stable until ex_ready.
- Two consecutive pops commit flags in order; the second merge uses the eflags value updated by the first.

Test Plan:
- Reset: hold reset low 2 cycles -> eflags = 32'h2, wb_v = 0, ex_ready = 1.
- Single op: push result 32'h0000_0180, flags CF|SF = 32'h81, mask 32'h8D5, count 1, datasize dword, wb_ready = 1 -> wb_v in next cycle; after pop eflags = 32'h83 (CF, SF set; ZF, PF, OF cleared).
- Count rules: count 0 with mask 32'h8D5 -> eflags unchanged. Count 3 with flags OF = 1 and prior OF = 0 -> OF stays 0 while CF updates.
- Backpressure: wb_ready = 0, push 3 ops -> ex_ready drops after the 2nd push and the 3rd is held. Then raise wb_ready -> results pop in order A, B, C, one per cycle.
- Simultaneous push and pop in ONE -> state stays ONE, next head is the new op, no bubble.
- Flush while FULL with wb_ready = 1 -> wb_v = 0 next cycle, eflags unchanged, ex_ready = 1. Byte op result 32'hDEAD_BEEF -> wb_result 32'h0000_00EF, wb_byte_en 4'b0001.
